// File: rtl/cal_pkg.sv
// Shared definitions for the calibration latency probe: FSM state encoding
// and the default counter width.
package cal_pkg;

    localparam int CAL_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_INIT0  = 3'd0,
        ST_INIT1  = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ARM    = 3'd3,
        ST_RUN    = 3'd4,
        ST_CLR0   = 3'd5,
        ST_CLR1   = 3'd6,
        ST_RESULT = 3'd7
    } cal_state_t;

endpackage

// File: rtl/cal_probe_stats.sv
// Running min/max/count over accepted (non-timeout) latency results.
// A clear request overrides an update in the same cycle.
module cal_probe_stats
    import cal_pkg::*;
#(
    parameter int CNT_W  = CAL_CNT_W,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd,
    input  logic              clr,
    input  logic [CNT_W-1:0]  lat,
    output logic [CNT_W-1:0]  stat_min,
    output logic [CNT_W-1:0]  stat_max,
    output logic [STAT_W-1:0] stat_cnt
);

    logic [CNT_W-1:0]  r_min;
    logic [CNT_W-1:0]  r_max;
    logic [STAT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_min <= '1;
            r_max <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_min <= '1;
            r_max <= '0;
            r_cnt <= '0;
        end else if (upd) begin
            if (lat < r_min) r_min <= lat;
            if (lat > r_max) r_max <= lat;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stat_min = r_min;
    assign stat_max = r_max;
    assign stat_cnt = r_cnt;

endmodule

// File: rtl/cal_latency_probe.sv
// Drives the external start/clear cycle counter for one trig_start/trig_stop
// measurement, returns the latency over valid/ready and keeps statistics.
module cal_latency_probe
    import cal_pkg::*;
#(
    parameter int CNT_W   = CAL_CNT_W,
    parameter int TIMEOUT = 250,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig_start,
    input  logic              trig_stop,
    output logic              cnt_start,
    output logic              cnt_clear,
    input  logic [CNT_W-1:0]  cnt_val,
    output logic              busy,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  m_lat,
    output logic              m_timeout,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_min,
    output logic [CNT_W-1:0]  stat_max,
    output logic [STAT_W-1:0] stat_cnt
);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    cal_state_t       r_state;
    logic             r_cnt_start;
    logic             r_cnt_clear;
    logic             r_busy;
    logic             r_m_valid;
    logic [CNT_W-1:0] r_m_lat;
    logic             r_m_timeout;
    logic             w_stat_upd;

    // Outputs are registered alongside the state they belong to, so each is
    // assigned on the transition into that state. INIT0 waits one cycle after
    // reset release so that cnt_clear covers both INIT0 and INIT1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_INIT0;
            r_cnt_start <= 1'b0;
            r_cnt_clear <= 1'b0;
            r_busy      <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_lat     <= '0;
            r_m_timeout <= 1'b0;
        end else begin
            r_cnt_start <= 1'b0;
            case (r_state)
                ST_INIT0: begin
                    r_cnt_clear <= 1'b1;
                    r_busy      <= 1'b1;
                    if (r_cnt_clear) r_state <= ST_INIT1;
                end
                ST_INIT1: begin
                    r_state     <= ST_IDLE;
                    r_cnt_clear <= 1'b0;
                    r_busy      <= 1'b0;
                end
                ST_IDLE: begin
                    if (trig_start) begin
                        r_state     <= ST_ARM;
                        r_cnt_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_m_timeout <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (trig_stop) begin
                        r_m_lat     <= CNT_W'(1);
                        r_cnt_clear <= 1'b1;
                        r_state     <= ST_CLR0;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Counter reads 0 two cycles after trig_start, hence +2.
                    if (trig_stop) begin
                        r_m_lat     <= cnt_val + CNT_W'(2);
                        r_cnt_clear <= 1'b1;
                        r_state     <= ST_CLR0;
                    end else if (cnt_val == TO_VAL) begin
                        r_m_lat     <= '1;
                        r_m_timeout <= 1'b1;
                        r_cnt_clear <= 1'b1;
                        r_state     <= ST_CLR0;
                    end
                end
                ST_CLR0: begin
                    r_state <= ST_CLR1;
                end
                ST_CLR1: begin
                    r_cnt_clear <= 1'b0;
                    r_m_valid   <= 1'b1;
                    r_state     <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_INIT0;
                end
            endcase
        end
    end

    assign w_stat_upd = (r_state == ST_RESULT) && m_ready && !r_m_timeout;

    cal_probe_stats #(
        .CNT_W  (CNT_W),
        .STAT_W (STAT_W)
    ) u_stats (
        .clk      (clk),
        .rst      (rst),
        .upd      (w_stat_upd),
        .clr      (stat_clr),
        .lat      (r_m_lat),
        .stat_min (stat_min),
        .stat_max (stat_max),
        .stat_cnt (stat_cnt)
    );

    assign cnt_start = r_cnt_start;
    assign cnt_clear = r_cnt_clear;
    assign busy      = r_busy;
    assign m_valid   = r_m_valid;
    assign m_lat     = r_m_lat;
    assign m_timeout = r_m_timeout;

endmodule

// File: tb/tb_cal_latency_probe.sv
// Directed bench for cal_latency_probe with a behavioural start/clear counter
// whose clear takes effect one cycle late.
module tb_cal_latency_probe;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 20;
    localparam int STAT_W  = 16;

    logic              clk        = 1'b0;
    logic              rst        = 1'b0;
    logic              trig_start = 1'b0;
    logic              trig_stop  = 1'b0;
    logic              m_ready    = 1'b0;
    logic              stat_clr   = 1'b0;
    logic              cnt_start;
    logic              cnt_clear;
    logic              busy;
    logic              m_valid;
    logic              m_timeout;
    logic [CNT_W-1:0]  cnt_val    = '0;
    logic [CNT_W-1:0]  m_lat;
    logic [CNT_W-1:0]  stat_min;
    logic [CNT_W-1:0]  stat_max;
    logic [STAT_W-1:0] stat_cnt;

    logic cm_run   = 1'b0;
    logic cm_clr_d = 1'b0;

    int n_chk = 0;
    int n_bad = 0;
    int vcyc;

    cal_latency_probe #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .STAT_W  (STAT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig_start (trig_start),
        .trig_stop  (trig_stop),
        .cnt_start  (cnt_start),
        .cnt_clear  (cnt_clear),
        .cnt_val    (cnt_val),
        .busy       (busy),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_lat      (m_lat),
        .m_timeout  (m_timeout),
        .stat_clr   (stat_clr),
        .stat_min   (stat_min),
        .stat_max   (stat_max),
        .stat_cnt   (stat_cnt)
    );

    always #5 clk = ~clk;

    // External counter: still counts in the first clear cycle, zeroes after the second.
    always @(posedge clk) begin
        cm_clr_d <= cnt_clear;
        if (cm_clr_d) begin
            cnt_val <= '0;
            cm_run  <= 1'b0;
        end else if (cnt_start) begin
            cm_run <= 1'b1;
        end else if (cm_run) begin
            cnt_val <= cnt_val + 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_seq(input string tag);
        int nclr;
        int c;
        nclr = 0;
        c    = 0;
        while (c < 20) begin
            tick();
            c++;
            if (cnt_clear) nclr++;
            if (!busy) break;
        end
        chk({tag, "_clr_cycles"}, nclr, 2);
        chk({tag, "_idle_cycle"}, c, 3);
    endtask

    // Start in cycle 0, stop in cycle n (n=0: no stop); returns m_valid cycle.
    task automatic run_meas(input int n, output int vc);
        int c;
        trig_start = 1'b1;
        tick();
        trig_start = 1'b0;
        c = 1;
        if (n > 0) begin
            while (c < n) begin
                tick();
                c++;
            end
            trig_stop = 1'b1;
            tick();
            trig_stop = 1'b0;
            c++;
        end
        while (!m_valid && c < 300) begin
            tick();
            c++;
        end
        vc = c;
    endtask

    task automatic ack();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic chk_stats(input string tag, input logic [7:0] mn, input logic [7:0] mx,
                             input logic [15:0] cn);
        chk({tag, "_min"}, stat_min, mn);
        chk({tag, "_max"}, stat_max, mx);
        chk({tag, "_cnt"}, stat_cnt, cn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_cnt_start", cnt_start, 0);
        chk("rst_cnt_clear", cnt_clear, 0);
        chk("rst_lat", m_lat, 0);
        chk("rst_timeout", m_timeout, 0);
        chk_stats("rst", 8'hFF, 8'h00, 16'd0);
        rst = 1'b1;
        init_seq("init");

        // Basic 10-cycle measurement with backpressure
        run_meas(10, vcyc);
        chk("r10_valid_cycle", vcyc, 13);
        chk("r10_lat", m_lat, 10);
        chk("r10_timeout", m_timeout, 0);
        repeat (5) tick();
        chk("r10_hold_valid", m_valid, 1);
        chk("r10_hold_lat", m_lat, 10);
        ack();
        chk("r10_valid_drop", m_valid, 0);
        chk("r10_busy_drop", busy, 0);
        chk_stats("r10", 8'd10, 8'd10, 16'd1);

        // Shortest latency: stop in the ARM cycle
        run_meas(1, vcyc);
        chk("r1_valid_cycle", vcyc, 4);
        chk("r1_lat", m_lat, 1);
        ack();

        // start+stop together in IDLE, then start during RUN is ignored
        trig_start = 1'b1;
        trig_stop  = 1'b1;
        tick();
        trig_start = 1'b0;
        trig_stop  = 1'b0;
        chk("ss_busy", busy, 1);
        chk("ss_cnt_start", cnt_start, 1);
        tick();
        tick();
        trig_start = 1'b1;
        tick();
        trig_start = 1'b0;
        tick();
        tick();
        trig_stop = 1'b1;
        tick();
        trig_stop = 1'b0;
        vcyc = 7;
        while (!m_valid && vcyc < 300) begin
            tick();
            vcyc++;
        end
        chk("ss_valid_cycle", vcyc, 9);
        chk("ss_lat", m_lat, 6);
        ack();
        tick();
        tick();
        chk("ss_no_requeue", busy, 0);

        // Timeout abort at cnt_val == TIMEOUT (cycle 22)
        run_meas(0, vcyc);
        chk("to_valid_cycle", vcyc, 25);
        chk("to_lat", m_lat, 8'hFF);
        chk("to_flag", m_timeout, 1);
        ack();
        chk_stats("to", 8'd1, 8'd10, 16'd3);

        // Statistics over 10, 4, 7 and clear
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk_stats("clr1", 8'hFF, 8'h00, 16'd0);
        run_meas(10, vcyc);
        ack();
        run_meas(4, vcyc);
        chk("r4_lat", m_lat, 4);
        ack();
        run_meas(7, vcyc);
        chk("r7_timeout", m_timeout, 0);
        ack();
        chk_stats("st3", 8'd4, 8'd10, 16'd3);
        run_meas(2, vcyc);
        m_ready  = 1'b1;
        stat_clr = 1'b1;
        tick();
        m_ready  = 1'b0;
        stat_clr = 1'b0;
        chk_stats("clr_prio", 8'hFF, 8'h00, 16'd0);

        // Reset in RUN at cnt_val=5
        trig_start = 1'b1;
        tick();
        trig_start = 1'b0;
        repeat (6) tick();
        chk("mid_cnt_val", cnt_val, 5);
        chk("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_clear", cnt_clear, 0);
        tick();
        tick();
        rst = 1'b1;
        init_seq("reinit");
        chk("reinit_cnt_zero", cnt_val, 0);
        run_meas(5, vcyc);
        chk("post_valid_cycle", vcyc, 8);
        chk("post_lat", m_lat, 5);
        ack();
        chk_stats("post", 8'd5, 8'd5, 16'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
